banked_data_mem: RTL and testbench

- Multi-cycle, four-bank data-memory responder that serves requests from the processor's memory stage.
- The memory stage (initiator) drives address, write data, enable and write strobe, and holds them while `stall` is high.
- This block accepts a request, returns a one-cycle `done` with read data a fixed number of cycles later, and flags unaligned or out-of-range requests on `err`.
- It replaces the single-cycle data memory model so that the pipeline's stall path can be exercised.

---
 rtl/banked_data_mem.sv | 145 ++++++++++++++
 tb/tb_banked_data_mem.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_data_mem.sv
// banked_data_mem
//   Four-bank data memory with a fixed response latency. It stands in for the
//   single-cycle data memory so that the memory stage's stall path gets
//   exercised.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset; released at a clock edge
//   addr      byte address; word index = addr[AW:1], bank = addr[2:1]
//   data_in   write data
//   enable    request valid
//   wr        1 = write, 0 = read (meaningful only while enable = 1)
//   data_out  read data; meaningful only while done = 1
//   done      one-cycle response pulse, LATENCY cycles after acceptance
//   stall     request not accepted this cycle
//   err       error response (unaligned or out of range); coincides with done
//   busy      per-bank occupied flags
//
// Handshake: enable is the request valid and stall is the inverse of ready.
// A request transfers in any cycle where enable = 1 and stall = 0. While
// stall = 1 nothing is latched and the initiator holds addr/data_in/wr; if it
// changes them anyway, the new values are evaluated as a fresh request.
// Error requests never stall. Every accepted request produces exactly one
// done pulse, in acceptance order, unless a reset intervenes.

module banked_data_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int LATENCY     = 2,
  parameter int BANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic [3:0]  busy
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(BANK_CYCLES) + 1;
  localparam logic [CW-1:0] BANK_LOAD   = CW'(BANK_CYCLES - 1);
  localparam logic [15:0]   DEPTH_LIMIT = 16'(MEM_DEPTH);

  logic [15:0]   mem [MEM_DEPTH];
  logic [CW-1:0] bankCnt [4];

  logic          pipeValid [LATENCY];
  logic          pipeErr   [LATENCY];
  logic [15:0]   pipeData  [LATENCY];

  logic [AW-1:0] wordIdx;
  logic [1:0]    bankSel;
  logic          errCond;
  logic          accept;
  logic          acceptOk;
  logic [15:0]   stageData;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign wordIdx = addr[AW:1];
  assign bankSel = addr[2:1];

  // Word address compared at 16 bits so MEM_DEPTH = 32768 is representable.
  assign errCond = enable & (addr[0] | ({1'b0, addr[15:1]} >= DEPTH_LIMIT));

  // Occupancy only matters for requests that would touch the array.
  assign stall    = enable & ~errCond & busy[bankSel];
  assign accept   = enable & ~stall;
  assign acceptOk = accept & ~errCond;

  // ---------------------------------------------------------------------------
  // Bank occupancy: loading BANK_CYCLES-1 at acceptance keeps busy high for
  // cycles T+1 .. T+BANK_CYCLES-1, so the bank is free again at T+BANK_CYCLES.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) bankCnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (acceptOk && (bankSel == 2'(b))) begin
          bankCnt[b] <= BANK_LOAD;
        end else if (bankCnt[b] != '0) begin
          bankCnt[b] <= bankCnt[b] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int b = 0; b < 4; b++) busy[b] = (bankCnt[b] != '0);
  end

  // ---------------------------------------------------------------------------
  // Storage array, cleared by reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (acceptOk && wr) begin
      mem[wordIdx] <= data_in;
    end
  end

  // Read data is captured at acceptance; writes and errors return zero.
  always_comb begin
    stageData = '0;
    if (acceptOk && !wr) stageData = mem[wordIdx];
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: stage 0 is loaded at the edge ending the acceptance
  // cycle, so stage LATENCY-1 is visible exactly LATENCY cycles later.
  // Idle stages carry zero data so data_out rests at 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipeValid[i] <= 1'b0;
        pipeErr[i]   <= 1'b0;
        pipeData[i]  <= '0;
      end
    end else begin
      pipeValid[0] <= accept;
      pipeErr[0]   <= accept & errCond;
      pipeData[0]  <= stageData;
      for (int i = 1; i < LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeErr[i]   <= pipeErr[i-1];
        pipeData[i]  <= pipeData[i-1];
      end
    end
  end

  assign done     = pipeValid[LATENCY-1];
  assign err      = pipeErr[LATENCY-1];
  assign data_out = pipeData[LATENCY-1];

endmodule

// File: tb/tb_banked_data_mem.sv
// tb_banked_data_mem
//   Bench for banked_data_mem. A behavioural model (word array, per-bank
//   "free again at cycle" numbers, and a queue of responses tagged with the
//   cycle they fall due) is compared against the DUT on every falling edge.
//   Directed scenarios add literal expectations read from a per-cycle history
//   of the DUT outputs; a randomized phase follows.

module tb_banked_data_mem;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int BC    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;
  logic [3:0]  busy;

  banked_data_mem #(
    .MEM_DEPTH  (DEPTH),
    .LATENCY    (LAT),
    .BANK_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .enable  (enable),
    .wr      (wr),
    .data_out(data_out),
    .done    (done),
    .stall   (stall),
    .err     (err),
    .busy    (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter, watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic        e;
    logic [15:0] d;
  } rsp_t;

  rsp_t        expQ[$];
  logic [15:0] memM [DEPTH];
  int          bankFree [4];

  // Observed DUT outputs by cycle, for the directed literal checks.
  logic [3:0]  busyHist [int];
  logic        doneHist [int];
  logic        errHist  [int];
  logic        stallHist[int];
  logic [15:0] dataHist [int];

  logic        mErr;
  logic        mStall;
  logic [3:0]  mBusy;
  logic [1:0]  mBank;
  logic        mDone;
  rsp_t        mRsp;
  rsp_t        mNew;

  initial begin
    for (int i = 0; i < DEPTH; i++) memM[i] = '0;
    for (int b = 0; b < 4; b++) bankFree[b] = 0;
  end

  always @(negedge clk) begin
    busyHist[cyc]  = busy;
    doneHist[cyc]  = done;
    errHist[cyc]   = err;
    stallHist[cyc] = stall;
    dataHist[cyc]  = data_out;

    if (!rst) begin
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_stall", 32'(stall), 0);
      expQ.delete();
      for (int i = 0; i < DEPTH; i++) memM[i] = '0;
      for (int b = 0; b < 4; b++) bankFree[b] = 0;
    end else begin
      mErr  = enable && (addr[0] || (int'(addr[15:1]) >= DEPTH));
      mBank = addr[2:1];
      for (int b = 0; b < 4; b++) mBusy[b] = (cyc < bankFree[b]);
      mStall = enable && !mErr && mBusy[mBank];

      chk("busy", 32'(busy), 32'(mBusy));
      chk("stall", 32'(stall), 32'(mStall));

      mDone = (expQ.size() > 0) && (expQ[0].due == cyc);
      chk("done", 32'(done), 32'(mDone));
      if (mDone) begin
        mRsp = expQ.pop_front();
        chk("err", 32'(err), 32'(mRsp.e));
        chk("data_out", 32'(data_out), 32'(mRsp.d));
      end else begin
        chk("err_idle", 32'(err), 0);
      end

      if (enable && !mStall) begin
        mNew.due = cyc + LAT;
        mNew.e   = mErr;
        mNew.d   = '0;
        if (!mErr) begin
          if (wr) memM[addr[15:1]] = data_in;
          else    mNew.d = memM[addr[15:1]];
          bankFree[mBank] = cyc + BC;
        end
        expQ.push_back(mNew);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all entered one time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc <= c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic w,
                       output int accCyc);
    addr    = a;
    data_in = d;
    wr      = w;
    enable  = 1'b1;
    accCyc  = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!stall) begin
        accCyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
    wr     = 1'b0;
    if (accCyc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %0h not accepted within 64 cycles", a);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int a0, a1, a2, a3, t, r, w, x;
  int kind, widx;
  logic [15:0] ra, rd;
  logic        rw;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Read of 0x0004 straight after reset.
    issue(16'h0004, 16'h0000, 1'b0, a0);
    waitUntil(a0 + 5);
    chk("s1_no_stall", 32'(stallHist[a0]), 0);
    chk("s1_done_early", 32'(doneHist[a0 + 1]), 0);
    chk("s1_done", 32'(doneHist[a0 + 2]), 1);
    chk("s1_data", 32'(dataHist[a0 + 2]), 32'h0000);
    chk("s1_busy1", 32'(busyHist[a0 + 1]), 32'b0100);
    chk("s1_busy2", 32'(busyHist[a0 + 2]), 32'b0100);
    chk("s1_busy3", 32'(busyHist[a0 + 3]), 32'b0100);
    chk("s1_busy4", 32'(busyHist[a0 + 4]), 32'b0000);
    idle(4);

    // Write then read the same bank: read waits out the occupancy.
    issue(16'h0010, 16'hBEEF, 1'b1, t);
    issue(16'h0010, 16'h0000, 1'b0, r);
    waitUntil(t + 7);
    chk("s2_stall", 32'(stallHist[t + 1]), 1);
    chk("s2_accept", 32'(r - t), 4);
    chk("s2_wdone", 32'(doneHist[t + 2]), 1);
    chk("s2_wdata", 32'(dataHist[t + 2]), 32'h0000);
    chk("s2_rdone", 32'(doneHist[t + 6]), 1);
    chk("s2_rdata", 32'(dataHist[t + 6]), 32'hBEEF);
    idle(6);

    // Four banks in consecutive cycles.
    issue(16'h0000, 16'h1111, 1'b1, a0);
    issue(16'h0002, 16'h2222, 1'b1, a1);
    issue(16'h0004, 16'h3333, 1'b1, a2);
    issue(16'h0006, 16'h4444, 1'b1, a3);
    waitUntil(a0 + 8);
    chk("s3_consecutive", 32'(a3 - a0), 3);
    for (int k = 2; k < 6; k++) chk("s3_done_train", 32'(doneHist[a0 + k]), 1);
    chk("s3_busy_a3", 32'(busyHist[a0 + 3]), 32'b0111);
    chk("s3_busy_a4", 32'(busyHist[a0 + 4]), 32'b1110);
    idle(6);

    // Unaligned and out-of-range reads.
    issue(16'h0003, 16'h0000, 1'b0, a0);
    issue(16'h0400, 16'h0000, 1'b0, a1);
    waitUntil(a1 + 4);
    chk("s4_no_stall", 32'(a1 - a0), 1);
    chk("s4_done1", 32'(doneHist[a0 + 2]), 1);
    chk("s4_err1", 32'(errHist[a0 + 2]), 1);
    chk("s4_data1", 32'(dataHist[a0 + 2]), 0);
    chk("s4_done2", 32'(doneHist[a1 + 2]), 1);
    chk("s4_err2", 32'(errHist[a1 + 2]), 1);
    chk("s4_data2", 32'(dataHist[a1 + 2]), 0);
    for (int k = a0; k <= a1 + 3; k++) chk("s4_busy", 32'(busyHist[k]), 0);
    idle(4);

    // Reset with a read in flight.
    issue(16'h0008, 16'h1234, 1'b1, w);
    issue(16'h0008, 16'h0000, 1'b0, r);
    chk("s5_accept", 32'(r - w), 4);
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async_done", 32'(done), 0);
    chk("s5_async_busy", 32'(busy), 0);
    chk("s5_async_err", 32'(err), 0);
    chk("s5_async_data", 32'(data_out), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    waitUntil(r + 4);
    chk("s5_no_done", 32'(doneHist[r + 2]), 0);
    issue(16'h0008, 16'h0000, 1'b0, x);
    waitUntil(x + 3);
    chk("s5_rdone", 32'(doneHist[x + 2]), 1);
    chk("s5_rdata", 32'(dataHist[x + 2]), 32'h0000);
    idle(4);

    // Randomized traffic; a small hot set of words makes hazards likely.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 7) widx = $urandom_range(0, 15);
      else                          widx = $urandom_range(0, DEPTH - 1);
      ra = 16'(widx * 2);
      if (kind == 0) ra = ra | 16'h0001;
      if (kind == 1) ra = 16'(($urandom_range(0, 32000) + DEPTH) * 2);
      rd = 16'($urandom_range(0, 65535));
      rw = 1'($urandom_range(0, 1));
      issue(ra, rd, rw, t);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
